// File: rtl/fan_ctrl_pkg.sv
// Shared constants, source codes, ramp FSM states and percent helpers
// for the fan duty sequencer.
package fan_ctrl_pkg;

    localparam int PWM_PERIOD = 40;

    localparam logic [2:0] SRC_IDLE  = 3'd0;
    localparam logic [2:0] SRC_S5    = 3'd1;
    localparam logic [2:0] SRC_PWRON = 3'd2;
    localparam logic [2:0] SRC_WDT   = 3'd3;
    localparam logic [2:0] SRC_FAIL  = 3'd4;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_UP    = 2'd1,
        ST_DOWN  = 2'd2,
        ST_FORCE = 2'd3
    } fan_state_e;

    // Any percent above 100 is treated as 100.
    function automatic logic [7:0] pct_clamp(input logic [7:0] p);
        return (p > 8'd100) ? 8'd100 : p;
    endfunction

    // Percent to PWM compare value over a 40-count period: (p*2)/5.
    function automatic logic [5:0] pct_to_cmp(input logic [7:0] p);
        logic [9:0] x;
        x = ({2'b00, pct_clamp(p)} * 10'd2) / 10'd5;
        return x[5:0];
    endfunction

endpackage

// File: rtl/fan_duty_sequencer_pwm.sv
// 25 kHz PWM generator: 40-step counter on the 1 us enable, compare value
// shadowed at the period wrap so a duty change never cuts a period short.
module fan_pwm_gen
    import fan_ctrl_pkg::*;
#(
    parameter logic [5:0] RST_CMP = 6'd40
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_1uSCE,
    input  logic [5:0] i_cmp,
    output logic       o_pwm
);

    localparam logic [5:0] CNT_MAX = 6'(PWM_PERIOD - 1);

    logic [5:0] cnt_q, cnt_d;
    logic [5:0] shadow_q, shadow_d;

    // Next counter/shadow values; the new compare is only taken at the wrap.
    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        if (i_1uSCE) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d    = 6'd0;
                shadow_d = i_cmp;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end
    end

    // Output is registered from the next-state values so it moves with the counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q    <= 6'd0;
            shadow_q <= RST_CMP;
            o_pwm    <= (RST_CMP != 6'd0);
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            o_pwm    <= (cnt_d < shadow_d);
        end
    end

endmodule

// File: rtl/fan_duty_sequencer.sv
// Fan duty sequencer: prioritized target select, power-on low-speed window,
// ramped duty FSM with fail-safe force, and the PWM output stage.
module fan_duty_sequencer
    import fan_ctrl_pkg::*;
#(
    parameter logic [7:0] RAMP_STEP  = 8'd5,
    parameter logic [7:0] LOWSPD_SEC = 8'd15,
    parameter logic [7:0] RST_DUTY   = 8'd100
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_1uSCE,
    input  logic       i_1000mSCE,
    input  logic       i_ramp_tick,
    input  logic       i_fail_full,
    input  logic       i_wdt_timeout,
    input  logic       i_pwr_on_st,
    input  logic       i_s5_en,
    input  logic [7:0] i_max_duty,
    input  logic [7:0] i_pwron_duty,
    input  logic [7:0] i_s5_duty,
    output logic       o_pwm,
    output logic [7:0] o_duty_pct,
    output logic [2:0] o_src,
    output logic       o_busy,
    output logic       o_lowspd_active
);

    localparam logic [7:0] RST_DUTY_C = pct_clamp(RST_DUTY);

    logic       pwr_q, win_q;
    logic [7:0] sec_q;
    logic       pwr_rise;
    logic [2:0] src_d, src_q;
    logic [7:0] target_d, target_q;
    fan_state_e state_q, state_d;
    logic [7:0] duty_q, duty_d, ramp_duty;

    assign pwr_rise = i_pwr_on_st & ~pwr_q;

    // Low-speed window: wdt or power loss kill it, a fresh S0 entry (re)starts it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pwr_q <= 1'b0;
            win_q <= 1'b0;
            sec_q <= 8'd0;
        end else begin
            pwr_q <= i_pwr_on_st;
            if (!i_pwr_on_st || i_wdt_timeout) begin
                win_q <= 1'b0;
                sec_q <= 8'd0;
            end else if (pwr_rise) begin
                win_q <= (LOWSPD_SEC != 8'd0);
                sec_q <= 8'd0;
            end else if (win_q && i_1000mSCE) begin
                sec_q <= sec_q + 8'd1;
                if (sec_q == LOWSPD_SEC - 8'd1) win_q <= 1'b0;
            end
        end
    end

    // Priority select of the requester and its (clamped) target duty.
    always_comb begin
        src_d    = SRC_IDLE;
        target_d = 8'd0;
        if (i_fail_full) begin
            src_d    = SRC_FAIL;
            target_d = 8'd100;
        end else if (i_pwr_on_st && i_wdt_timeout) begin
            src_d    = SRC_WDT;
            target_d = pct_clamp(i_max_duty);
        end else if (i_pwr_on_st && win_q) begin
            src_d    = SRC_PWRON;
            target_d = pct_clamp(i_pwron_duty);
        end else if (!i_pwr_on_st && i_s5_en) begin
            src_d    = SRC_S5;
            target_d = pct_clamp(i_s5_duty);
        end
    end

    // Register the winning source and target.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            src_q    <= SRC_IDLE;
            target_q <= 8'd0;
        end else begin
            src_q    <= src_d;
            target_q <= target_d;
        end
    end

    function automatic fan_state_e dir_of(input logic [7:0] tgt, input logic [7:0] d);
        if (tgt > d)      return ST_UP;
        else if (tgt < d) return ST_DOWN;
        else              return ST_HOLD;
    endfunction

    // One ramp step toward target_q, landing exactly on it when closer than a step.
    always_comb begin
        ramp_duty = duty_q;
        if (target_q > duty_q)
            ramp_duty = (target_q - duty_q <= RAMP_STEP) ? target_q : duty_q + RAMP_STEP;
        else if (target_q < duty_q)
            ramp_duty = (duty_q - target_q <= RAMP_STEP) ? target_q : duty_q - RAMP_STEP;
    end

    // Ramp FSM: fail-safe forces 100 and blocks ticks; otherwise step on tick.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        if (src_q == SRC_FAIL) begin
            state_d = ST_FORCE;
            duty_d  = 8'd100;
        end else begin
            case (state_q)
                ST_UP, ST_DOWN: begin
                    if (i_ramp_tick) duty_d = ramp_duty;
                    state_d = dir_of(target_q, duty_d);
                end
                default: state_d = dir_of(target_q, duty_q);
            endcase
        end
    end

    // FSM state and applied duty registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_HOLD;
            duty_q  <= RST_DUTY_C;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
        end
    end

    fan_pwm_gen #(
        .RST_CMP (pct_to_cmp(RST_DUTY_C))
    ) u_pwm (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_1uSCE (i_1uSCE),
        .i_cmp   (pct_to_cmp(duty_q)),
        .o_pwm   (o_pwm)
    );

    assign o_duty_pct      = duty_q;
    assign o_src           = src_q;
    assign o_busy          = (state_q != ST_HOLD);
    assign o_lowspd_active = win_q;

endmodule

// File: doc/fan_duty_sequencer.md
# fan_duty_sequencer

CPLD-side fan duty controller that sits behind the BMC-watchdog fan logic. It selects a target duty from prioritized requesters: fail-safe full speed, watchdog timeout, power-on low-speed window, S5 setting and idle. It ramps the applied duty toward that target in fixed percent steps and drives one 25 kHz PWM output. The fan output mux replicates this output to every fan when the CPLD owns the fans.

## Interface
- RAMP_STEP, 8'd5, percent change applied per i_ramp_tick (1..100)
- LOWSPD_SEC, 8'd15, power-on low-speed window length in seconds (0 = window disabled)
- RST_DUTY, 8'd100, applied duty (percent) at reset
- i_clk  input  1  system clock; the only clock
- i_rst_n  input  1  reset, synchronous, active-low
- i_1uSCE  input  1  1 µs clock-enable pulse (one i_clk wide), advances PWM counter
- i_1000mSCE  input  1  1 s clock-enable pulse, times low-speed window
- i_ramp_tick  input  1  ramp-step enable pulse (one i_clk wide)
- i_fail_full  input  1  fail-safe request (fan fail/thermal trip): force 100 %
- i_wdt_timeout  input  1  BMC heartbeat watchdog expired
- i_pwr_on_st  input  1  host in S0
- i_s5_en  input  1  fans enabled in S5
- i_max_duty  input  8  percent used on watchdog timeout in S0
- i_pwron_duty  input  8  percent during power-on low-speed window
- i_s5_duty  input  8  percent in S5
- o_pwm  output  1  registered PWM, 40 × 1 µs period
- o_duty_pct  output  8  currently applied duty, percent
- o_src  output  3  registered winning requester code
- o_busy  output  1  1 while applied duty ≠ target
- o_lowspd_active  output  1  low-speed window running

## Operation
- All percent inputs clamp to 100 when >100.
- Priority, evaluated every cycle and registered into target_q/o_src:
  - SRC_FAIL=4: i_fail_full; target 100; bypasses the ramp.
  - SRC_WDT=3: i_pwr_on_st & i_wdt_timeout; target i_max_duty.
  - SRC_PWRON=2: i_pwr_on_st & window active; target i_pwron_duty.
  - SRC_S5=1: ~i_pwr_on_st & i_s5_en; target i_s5_duty.
  - SRC_IDLE=0: otherwise; target 0.
- Low-speed window:
  - Starts on a registered rising edge of i_pwr_on_st, only when i_wdt_timeout=0. Second counter cleared.
  - Ends when the counter reaches LOWSPD_SEC (counted on i_1000mSCE), when i_pwr_on_st falls, or when i_wdt_timeout asserts.
  - A new rising edge while the window runs restarts it.
- FSM states: HOLD, UP, DOWN, FORCE.
  - HOLD→UP when target_q > duty; HOLD→DOWN when target_q < duty.
  - Any state→FORCE when src is SRC_FAIL. In FORCE, duty=100 on the next cycle.
  - FORCE exits to HOLD/UP/DOWN when i_fail_full drops; no ramp until that exit.
  - UP/DOWN: on i_ramp_tick, duty ± RAMP_STEP, saturating at target_q (never overshoots, never wraps below 0).
  - UP/DOWN→HOLD when duty == target_q. UP↔DOWN directly if the target crosses the current duty.
- PWM generation:
  - Counter 0..39, increments on i_1uSCE, wraps 39→0.
  - Compare value = (duty×2)/5 (0..40), latched into a shadow register only at wrap, so there are no mid-period glitches.
  - o_pwm = (cnt < shadow). 100 % gives constant 1; 0 % gives constant 0.
- o_busy = (state ≠ HOLD).

## Timing
- Reset (i_rst_n low at a clk edge):
  - duty = RST_DUTY; shadow = (RST_DUTY×2)/5; cnt = 0.
  - o_pwm = 1 if RST_DUTY > 0; o_src = 0; o_lowspd_active = 0; state HOLD; target_q = 0.
  - With target_q=0 and duty=RST_DUTY, the FSM leaves HOLD on the first cycle after reset.
- Reset mid-ramp or mid-window aborts immediately to the reset values.
- Request-to-target latency is 1 clk (target_q). A ramp tick in the same cycle as a source change uses the old target_q.
- Duty-to-o_pwm latency: effective at the next counter wrap, within 40 µs + 1 clk.
- When i_ramp_tick and an entry into FORCE coincide, FORCE wins.
- A 1 s tick on the same cycle as a window restart counts from 0.

## Structure
- Package fan_ctrl_pkg holds:
  - PWM_PERIOD=40
  - SRC_* codes (3 bit) and FSM state encodings
  - function pct_clamp (clamps percent to 100)
  - function pct_to_cmp (percent → compare value)
- Sub-module fan_pwm_gen contains the 1 µs counter, shadow register and compare. Its inputs are cmp[5:0] and i_1uSCE; its output is o_pwm.
- The top level holds source select, low-speed window timer and ramp FSM.

## Test plan
- Reset, then idle (all requests 0, RAMP_STEP=5): duty steps 100→95→…→0, one step per i_ramp_tick (20 ticks). o_busy drops on the final step. o_pwm is constant 0 afterwards.
- Rising edge of i_pwr_on_st with i_pwron_duty=30 and LOWSPD_SEC=3:
  - o_src=2; duty ramps to 30.
  - After 3 i_1000mSCE pulses the window ends and o_src=0.
- Same window with i_wdt_timeout asserted at second 1 and i_max_duty=80: o_lowspd_active drops within 1 clk, o_src=3, duty ramps up to 80.
- i_fail_full pulsed during a ramp at duty 40:
  - Duty=100 two clks after the request (FORCE); ramp ticks ignored.
  - After release, duty ramps back toward the target.
- RAMP_STEP=7, duty 0, target i_s5_duty=20: duty sequence 0→7→14→20 (saturates, no overshoot).
- Duty switched 50→25 mid-period: o_pwm high time is 20 µs until the wrap, then 10 µs of every 40 µs. There are no glitches.
